// File: rtl/trng_reader.sv
// Fetches 128-bit samples from a TRNG source, screens them for stuck and repeated values,
// and serves each accepted sample to the consumer as four 32-bit words over valid/ready.
module trng_reader #(
  parameter int TIMEOUT = 1023,
  parameter int WORDS   = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic         trng_rst,
  output logic         trng_go,
  input  logic         trng_done,
  input  logic [127:0] trng_data,
  output logic [31:0]  rd_data,
  output logic         rd_valid,
  input  logic         rd_ready,
  output logic         err,
  output logic [1:0]   err_code
);

  // state | meaning
  // IDLE  | waiting for en
  // SRST  | one-cycle reset pulse to the source
  // GO    | one-cycle start pulse, timeout counter cleared
  // WAIT  | waiting for trng_done, counting toward TIMEOUT
  // CHECK | stuck-value and repetition screening of the captured sample
  // SERVE | presenting words 0..WORDS-1 on rd_data
  // ERR   | fault latched, left only through rst
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SRST  = 3'd1,
    GO    = 3'd2,
    WAIT  = 3'd3,
    CHECK = 3'd4,
    SERVE = 3'd5,
    ERR   = 3'd6
  } state_t;

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam int IW = $clog2(WORDS);

  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_STUCK   = 2'b10;
  localparam logic [1:0] ERR_REPEAT  = 2'b11;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [127:0]   sample_q, sample_d;
  logic [127:0]   prev_q, prev_d;
  logic           prev_valid_q, prev_valid_d;
  logic [1:0]     err_code_q, err_code_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      sample_q     <= '0;
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      err_code_q   <= 2'b00;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      sample_q     <= sample_d;
      prev_q       <= prev_d;
      prev_valid_q <= prev_valid_d;
      err_code_q   <= err_code_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    sample_d     = sample_q;
    prev_d       = prev_q;
    prev_valid_d = prev_valid_q;
    err_code_d   = err_code_q;

    case (state_q)
      IDLE: begin
        if (en) state_d = SRST;
      end
      SRST: state_d = GO;
      GO: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // done wins over a timeout landing in the same cycle
        if (trng_done) begin
          sample_d = trng_data;
          state_d  = CHECK;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(TIMEOUT - 1)) begin
            err_code_d = ERR_TIMEOUT;
            state_d    = ERR;
          end
        end
      end
      CHECK: begin
        if (sample_q == '0 || sample_q == '1) begin
          err_code_d = ERR_STUCK;
          state_d    = ERR;
        end else if (prev_valid_q && sample_q == prev_q) begin
          err_code_d = ERR_REPEAT;
          state_d    = ERR;
        end else begin
          prev_d       = sample_q;
          prev_valid_d = 1'b1;
          idx_d        = '0;
          state_d      = SERVE;
        end
      end
      SERVE: begin
        if (rd_ready) begin
          if (idx_q == IW'(WORDS - 1)) begin
            idx_d   = '0;
            state_d = en ? SRST : IDLE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      ERR: state_d = ERR;
      default: state_d = IDLE;
    endcase
  end

  assign trng_rst = (state_q == SRST);
  assign trng_go  = (state_q == GO);
  assign rd_valid = (state_q == SERVE);
  assign rd_data  = rd_valid ? sample_q[{idx_q, 5'd0} +: 32] : 32'h0;
  assign err      = (state_q == ERR);
  assign err_code = err_code_q;

endmodule

// File: tb/tb_trng_reader.sv
// Directed bench for trng_reader: a source model answers go pulses, a scoreboard queue
// holds expected words and a negedge monitor checks every handshake and stall.
`timescale 1ns/1ps
module tb_trng_reader;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic         trng_rst;
  logic         trng_go;
  logic         trng_done = 1'b0;
  logic [127:0] trng_data;
  logic [31:0]  rd_data;
  logic         rd_valid;
  logic         rd_ready;
  logic         err;
  logic [1:0]   err_code;

  logic [127:0] src_data;
  logic         src_never;
  int           src_cnt = 0;

  logic [31:0]  exp_q[$];
  int n_cmp = 0;
  int n_fail = 0;
  int hs_cnt = 0;
  int go_cnt = 0;
  int rst_cnt = 0;

  localparam logic [127:0] D1 = 128'h3dd16a0a_3554db07_0e0b00ce_143b7344;
  localparam logic [127:0] D2 = 128'h89abcdef_01234567_deadbeef_cafef00d;

  trng_reader #(.TIMEOUT(1023), .WORDS(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .trng_rst (trng_rst),
    .trng_go  (trng_go),
    .trng_done(trng_done),
    .trng_data(trng_data),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .err      (err),
    .err_code (err_code)
  );

  always #5 clk = ~clk;

  // Source model: done rises five cycles after the go pulse, sticky until trng_rst.
  always @(posedge clk) begin
    if (trng_rst) begin
      trng_done <= 1'b0;
      src_cnt   <= 0;
    end else if (trng_go) begin
      src_cnt <= src_never ? 0 : 4;
    end else if (src_cnt != 0) begin
      src_cnt <= src_cnt - 1;
      if (src_cnt == 1) trng_done <= 1'b1;
    end
  end
  assign trng_data = trng_done ? src_data : 128'h0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every handshake pops the scoreboard; a stall must hold the expected word.
  always @(negedge clk) begin
    if (trng_go)  go_cnt++;
    if (trng_rst) rst_cnt++;
    if (rd_valid) begin
      if (rd_ready) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_word: got %0h expected no word", rd_data);
        end else begin
          chk("word", rd_data, exp_q.pop_front());
        end
      end else if (exp_q.size() != 0) begin
        chk("stall_hold", rd_data, exp_q[0]);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic push_sample(input logic [127:0] d);
    for (int i = 0; i < 4; i++) exp_q.push_back(d[32*i +: 32]);
  endtask

  task automatic wait_valid(output int lat, input int limit);
    lat = 0;
    while (lat < limit) begin
      tick(1);
      lat++;
      if (rd_valid) break;
    end
  endtask

  task automatic wait_err(output int lat, input int limit);
    lat = 0;
    while (lat < limit) begin
      tick(1);
      lat++;
      if (err) break;
    end
  endtask

  task automatic do_reset;
    rst = 1'b1;
    en = 1'b0;
    rd_ready = 1'b0;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_rd_valid"}, rd_valid, 0);
    chk({tag, "_rd_data"},  rd_data,  0);
    chk({tag, "_err"},      err,      0);
    chk({tag, "_err_code"}, err_code, 0);
    chk({tag, "_trng_go"},  trng_go,  0);
    chk({tag, "_trng_rst"}, trng_rst, 0);
  endtask

  initial begin
    int lat, go0, rs0, hs0;
    rst = 1'b1; en = 1'b0; rd_ready = 1'b0; src_data = '0; src_never = 1'b0;
    tick(3);
    chk_zero_outputs("reset");
    rst = 1'b0;
    tick(1);

    // Normal fetch, consumer always ready
    src_data = D1;
    push_sample(D1);
    rd_ready = 1'b1;
    go0 = go_cnt; rs0 = rst_cnt; hs0 = hs_cnt;
    en = 1'b1;
    wait_valid(lat, 50);
    chk("first_word_latency", lat, 9);
    tick(4);
    chk("words_consecutive", hs_cnt - hs0, 4);
    chk("go_pulses_one", go_cnt - go0, 1);
    chk("rst_pulses_one", rst_cnt - rs0, 1);
    chk("valid_low_after_sample", rd_valid, 0);

    // Second fetch returns the same value -> repetition fault
    en = 1'b0;
    wait_err(lat, 50);
    chk("repeat_err_latency", lat, 8);
    chk("repeat_err_code", err_code, 2'b11);
    tick(5);
    chk("repeat_err_sticky", err, 1);
    chk("repeat_no_valid", rd_valid, 0);
    chk("repeat_go_pulses", go_cnt - go0, 2);

    // Source never completes -> timeout
    do_reset;
    src_never = 1'b1;
    go0 = go_cnt;
    en = 1'b1;
    tick(1);
    en = 1'b0;
    wait_err(lat, 1100);
    chk("timeout_latency", lat + 1, 1026);
    chk("timeout_err_code", err_code, 2'b01);
    tick(10);
    chk("timeout_go_pulses", go_cnt - go0, 1);
    chk("timeout_no_valid", rd_valid, 0);
    src_never = 1'b0;

    // All-ones sample -> stuck fault, nothing served
    do_reset;
    src_data = '1;
    hs0 = hs_cnt;
    en = 1'b1;
    tick(1);
    en = 1'b0;
    wait_err(lat, 50);
    chk("stuck_err", err, 1);
    chk("stuck_err_code", err_code, 2'b10);
    chk("stuck_no_words", hs_cnt - hs0, 0);
    chk("stuck_no_valid", rd_valid, 0);

    // Back-pressure 1,0,0,1 and en dropped after word 1
    do_reset;
    src_data = D2;
    push_sample(D2);
    rd_ready = 1'b1;
    go0 = go_cnt; rs0 = rst_cnt; hs0 = hs_cnt;
    en = 1'b1;
    wait_valid(lat, 50);
    chk("stall_first_latency", lat, 9);
    tick(1); rd_ready = 1'b0;
    tick(1);
    tick(1); rd_ready = 1'b1;
    tick(1); en = 1'b0;
    chk("stall_hs_after_word1", hs_cnt - hs0, 2);
    tick(2);
    chk("stall_hs_total", hs_cnt - hs0, 4);
    chk("stall_idle_valid", rd_valid, 0);
    tick(10);
    chk("stall_no_refetch_go", go_cnt - go0, 1);
    chk("stall_no_refetch_rst", rst_cnt - rs0, 1);
    chk("stall_hs_final", hs_cnt - hs0, 4);
    chk("stall_queue_drained", exp_q.size(), 0);

    // Reset while waiting on the source
    en = 1'b1;
    tick(1);
    en = 1'b0;
    tick(3);
    rst = 1'b1;
    tick(1);
    chk_zero_outputs("rst_in_wait");
    rst = 1'b0;

    // Reset in the middle of serving; same sample must be accepted afterwards
    exp_q.push_back(D2[31:0]);
    rd_ready = 1'b0;
    hs0 = hs_cnt;
    en = 1'b1;
    tick(1);
    en = 1'b0;
    wait_valid(lat, 50);
    chk("after_rst_same_sample_latency", lat + 1, 9);
    rd_ready = 1'b1;
    tick(1);
    rd_ready = 1'b0;
    rst = 1'b1;
    tick(1);
    chk_zero_outputs("rst_in_serve");
    chk("rst_in_serve_hs", hs_cnt - hs0, 1);
    rst = 1'b0;

    push_sample(D2);
    rd_ready = 1'b1;
    hs0 = hs_cnt;
    en = 1'b1;
    tick(1);
    en = 1'b0;
    lat = 0;
    while (lat < 50 && (hs_cnt - hs0) < 4) begin
      tick(1);
      lat++;
    end
    chk("reaccept_hs", hs_cnt - hs0, 4);
    chk("reaccept_no_err", err, 0);
    tick(3);
    chk("reaccept_idle", rd_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200us");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/trng_reader.md
TRNG_READER -- requirements
Module: trng_reader

Interface
REQ-001 SHALL have parameter TIMEOUT, default 1023, giving the maximum WAIT-state cycles before an error is declared.
REQ-002 SHALL have parameter WORDS, fixed at 4, giving the number of 32-bit words served per 128-bit sample.
REQ-003 SHALL have port clk  in  1  system clock; all logic rising-edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port en  in  1  enables sample fetching.
REQ-006 SHALL have port trng_rst  out  1  reset pulse to the TRNG source.
REQ-007 SHALL have port trng_go  out  1  start pulse to the TRNG source.
REQ-008 SHALL have port trng_done  in  1  source completion; sticky high until the source is reset.
REQ-009 SHALL have port trng_data  in  128  source sample; valid while trng_done=1.
REQ-010 SHALL have port rd_data  out  32  word to the consumer.
REQ-011 SHALL have port rd_valid  out  1  rd_data valid.
REQ-012 SHALL have port rd_ready  in  1  consumer accepts the word.
REQ-013 SHALL have port err  out  1  sticky fault flag.
REQ-014 SHALL have port err_code  out  2  fault cause: 00 none, 01 timeout, 10 stuck value (all-0/all-1), 11 repetition.

Function
REQ-015 SHALL implement FSM states IDLE, SRST, GO, WAIT, CHECK, SERVE, ERR.
REQ-016 SHALL move IDLE->SRST when en=1; otherwise hold IDLE.
REQ-017 SHALL, in SRST, drive trng_rst=1 for exactly one cycle, then move to GO.
REQ-018 SHALL, in GO, drive trng_go=1 for exactly one cycle, clear the timeout counter, then move to WAIT.
REQ-019 SHALL drive trng_rst and trng_go to 0 in all other states.
REQ-020 SHALL, in WAIT, increment a timeout counter each cycle trng_done=0.
REQ-021 SHALL move WAIT->ERR with err_code=01 when the counter reaches TIMEOUT with trng_done still 0.
REQ-022 SHALL, when trng_done=1 in WAIT, capture trng_data into a 128-bit sample register that cycle and move to CHECK; trng_done takes priority over a same-cycle timeout.
REQ-023 SHALL, in CHECK (one cycle), go to ERR with code 10 when the sample is all-zero or all-one.
REQ-024 SHALL otherwise go to ERR with code 11 when prev_valid=1 and the sample equals the previous accepted sample.
REQ-025 SHALL otherwise store the sample as previous, set prev_valid=1, reset the word index to 0, and move to SERVE.
REQ-026 SHALL, in SERVE, assert rd_valid=1 with rd_data = sample[32*idx+31:32*idx] (word 0 = bits 31:0).
REQ-027 SHALL hold rd_data stable while rd_valid=1 and rd_ready=0.
REQ-028 SHALL advance idx on rd_valid & rd_ready; after word index 3 is accepted, go to SRST if en=1, else IDLE.
REQ-029 SHALL finish serving the current sample when en drops mid-SERVE, fetching no new sample afterwards.
REQ-030 SHALL ignore en deasserted during SRST/GO/WAIT/CHECK; the fetch completes.
REQ-031 SHALL hold rd_valid=0 outside SERVE.
REQ-032 SHALL make ERR absorbing: err=1, err_code held, rd_valid=0, no TRNG pulses; exit only by rst.
REQ-033 SHALL give a first word latency, from en rising in IDLE, of SRST(1)+GO(1)+WAIT(n)+CHECK(1), with rd_valid high in the cycle after CHECK.

Reset
REQ-034 SHALL, on rst, enter IDLE and clear rd_valid, rd_data, err, err_code, trng_go, trng_rst, idx, timeout counter, sample, previous sample and prev_valid.
REQ-035 SHALL let rst mid-operation (any state) abort immediately; no partial word is presented after reset.

Verification
REQ-036 SHALL cover: en=1, source model asserts done 5 cycles after go with data 0x3dd16a0a3554db070e0b00ce143b7344, rd_ready=1 -> one trng_rst pulse, one trng_go pulse, then words 0x143b7344, 0x0e0b00ce, 0x3554db07, 0x3dd16a0a on consecutive cycles.
REQ-037 SHALL cover: same source returning that identical value on the second fetch -> err=1, err_code=11, rd_valid=0 thereafter.
REQ-038 SHALL cover: source never asserts done, TIMEOUT=1023 -> ERR with err_code=01 after 1023 WAIT cycles, and no further go pulses.
REQ-039 SHALL cover: source returns all-ones 128-bit -> err_code=10, no words served.
REQ-040 SHALL cover: rd_ready toggling 1,0,0,1 during SERVE -> rd_data constant while stalled; exactly 4 handshakes per sample; en dropped after word 1 -> remaining 2 words served, then IDLE.
REQ-041 SHALL cover: rst asserted in WAIT and in SERVE -> next cycle all outputs 0, state IDLE, prev_valid cleared (the same sample is accepted again afterwards).
